parallel_to_serial_tx: RTL and testbench

Transmit side of the serial_to_parallel link. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clk, MSB first by default. Emits framing strobes (serial_valid, last, done), so a serial_to_parallel receiver on the far end captures the word by driving its load from done. Back-to-back words stream with no idle gap.

---
 rtl/p2s_pkg.sv | 11 +
 rtl/parallel_to_serial_tx.sv | 89 ++++++++
 tb/tb_parallel_to_serial_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// Shared types for the parallel-to-serial transmitter.
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_t;

  localparam int P2S_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/parallel_to_serial_tx.sv
// Parallel-to-serial transmitter: accepts a word on load && ready and shifts it
// out one bit per clock with serial_valid/last/done framing strobes.
module parallel_to_serial_tx
  import p2s_pkg::*;
#(
  parameter int WIDTH     = P2S_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  p2s_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_serial_out;
  logic             r_serial_valid;
  logic             r_last;
  logic             r_done;

  logic             w_ready;
  logic             w_accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // A new word may land in the final-bit cycle so words stream without a gap.
  assign w_ready  = (r_state == P2S_IDLE) || (r_cnt == CNT_ZERO);
  assign w_accept = load && w_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= P2S_IDLE;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_last         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= r_last;
      if (w_accept) begin
        r_state        <= P2S_SHIFT;
        r_cnt          <= CNT_FIRST;
        r_serial_out   <= first_bit(data_in);
        r_shift        <= shift_once(data_in);
        r_serial_valid <= 1'b1;
        r_last         <= 1'b0;
      end else if (r_state == P2S_SHIFT && r_cnt != CNT_ZERO) begin
        r_serial_out   <= first_bit(r_shift);
        r_shift        <= shift_once(r_shift);
        r_cnt          <= r_cnt - CNT_ONE;
        r_serial_valid <= 1'b1;
        r_last         <= (r_cnt == CNT_ONE);
      end else begin
        r_state        <= P2S_IDLE;
        r_serial_out   <= 1'b0;
        r_serial_valid <= 1'b0;
        r_last         <= 1'b0;
      end
    end
  end

  assign ready        = w_ready;
  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign last         = r_last;
  assign done         = r_done;
  assign busy         = (r_state == P2S_SHIFT);

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Directed bench for parallel_to_serial_tx: 32-bit MSB-first and 8-bit LSB-first instances.
module tb_parallel_to_serial_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic        ready, serial_out, serial_valid, last, done, busy;

  logic [7:0]  data8;
  logic        load8;
  logic        ready8, so8, valid8, last8, done8, busy8;

  logic [31:0] rx_sh;
  logic [31:0] rx_par;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial_tx #(.WIDTH(32), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .last(last), .done(done), .busy(busy)
  );

  parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .data_in(data8), .load(load8),
    .ready(ready8), .serial_out(so8), .serial_valid(valid8),
    .last(last8), .done(done8), .busy(busy8)
  );

  // Far-end receiver: MSB-first shift register captured on done.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sh  <= '0;
      rx_par <= '0;
    end else begin
      if (serial_valid) rx_sh <= {rx_sh[30:0], serial_out};
      if (done) rx_par <= rx_sh;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    data_in = w;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Samples the current cycle first, then advances; gathers valid bits MSB-first.
  task automatic collect(input int ncyc, output logic [31:0] got, output int nvalid, output int ndone);
    got = '0; nvalid = 0; ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (serial_valid) begin
        got = {got[30:0], serial_out};
        nvalid++;
      end
      if (done) ndone++;
      tick();
    end
  endtask

  logic [31:0] w;
  logic [31:0] got;
  int nvalid, ndone;

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; load8 = 1'b0; data8 = '0;
    #1;
    check("rst_sout",  {63'd0, serial_out},   64'd0);
    check("rst_valid", {63'd0, serial_valid}, 64'd0);
    check("rst_last",  {63'd0, last},         64'd0);
    check("rst_done",  {63'd0, done},         64'd0);
    check("rst_busy",  {63'd0, busy},         64'd0);
    check("rst_ready", {63'd0, ready},        64'd1);
    check("rst_ready8", {63'd0, ready8},      64'd1);
    // load is ignored while reset is held
    load = 1'b1; data_in = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_ignore_load", {63'd0, serial_valid}, 64'd0);
    load = 1'b0;
    reset = 1'b0;
    tick();

    // Test 1: single word, cycle-exact framing
    w = 32'hB4F0_0001;
    send(w);
    for (int k = 1; k <= 32; k++) begin
      check($sformatf("t1_bit%0d", k),   {63'd0, serial_out},   {63'd0, w[32-k]});
      check($sformatf("t1_vld%0d", k),   {63'd0, serial_valid}, 64'd1);
      check($sformatf("t1_last%0d", k),  {63'd0, last},         {63'd0, k == 32});
      check($sformatf("t1_done%0d", k),  {63'd0, done},         64'd0);
      check($sformatf("t1_ready%0d", k), {63'd0, ready},        {63'd0, k == 32});
      check($sformatf("t1_busy%0d", k),  {63'd0, busy},         64'd1);
      tick();
    end
    check("t1_done33",  {63'd0, done},         64'd1);
    check("t1_vld33",   {63'd0, serial_valid}, 64'd0);
    check("t1_last33",  {63'd0, last},         64'd0);
    check("t1_busy33",  {63'd0, busy},         64'd0);
    check("t1_ready33", {63'd0, ready},        64'd1);
    check("t6_rx_idle", rx_par,                64'd0);
    tick();
    check("t1_done34",  {63'd0, done},         64'd0);
    check("t6_loopback", {32'd0, rx_par},      64'hB4F0_0001);

    // Test 2: back-to-back with load held
    data_in = 32'hFFFF_FFFF; load = 1'b1;
    tick();
    data_in = 32'h0000_0000;
    for (int k = 1; k <= 64; k++) begin
      check($sformatf("t2_bit%0d", k),  {63'd0, serial_out},   {63'd0, k <= 32});
      check($sformatf("t2_vld%0d", k),  {63'd0, serial_valid}, 64'd1);
      check($sformatf("t2_done%0d", k), {63'd0, done},         {63'd0, k == 33});
      if (k == 33) load = 1'b0;
      tick();
    end
    check("t2_done65", {63'd0, done},         64'd1);
    check("t2_vld65",  {63'd0, serial_valid}, 64'd0);
    tick();

    // Test 3: load pulse while busy is ignored
    send(32'hA5A5_A5A5);
    got = '0; nvalid = 0; ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      if (serial_valid) begin
        got = {got[30:0], serial_out};
        nvalid++;
      end
      if (done) ndone++;
      if (k == 9)  begin load = 1'b1; data_in = 32'h1234_5678; end
      if (k == 10) load = 1'b0;
      tick();
    end
    check("t3_word",  {32'd0, got}, 64'hA5A5_A5A5);
    check("t3_nvld",  nvalid,       64'd32);
    check("t3_ndone", ndone,        64'd1);

    // Test 4: reset mid-word
    send(32'hDEAD_BEEF);
    for (int k = 1; k < 12; k++) tick();
    check("t4_midword_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_sout",  {63'd0, serial_out},   64'd0);
    check("t4_valid", {63'd0, serial_valid}, 64'd0);
    check("t4_last",  {63'd0, last},         64'd0);
    check("t4_busy",  {63'd0, busy},         64'd0);
    tick();
    reset = 1'b0;
    check("t4_ready", {63'd0, ready}, 64'd1);
    collect(4, got, nvalid, ndone);
    check("t4_nodone", ndone, 64'd0);
    send(32'h0000_0003);
    collect(36, got, nvalid, ndone);
    check("t4_word",  {32'd0, got}, 64'h3);
    check("t4_nvld",  nvalid,       64'd32);
    check("t4_ndone", ndone,        64'd1);

    // Test 5: WIDTH=8, LSB first
    data8 = 8'h01; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("t5_bit%0d", k),  {63'd0, so8},    {63'd0, k == 1});
      check($sformatf("t5_vld%0d", k),  {63'd0, valid8}, {63'd0, k <= 8});
      check($sformatf("t5_last%0d", k), {63'd0, last8},  {63'd0, k == 8});
      check($sformatf("t5_done%0d", k), {63'd0, done8},  {63'd0, k == 9});
      check($sformatf("t5_busy%0d", k), {63'd0, busy8},  {63'd0, k <= 8});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
